// File: rtl/hpdmc_ddr_rdcapture.sv
// Read-data capture for the hpdmc DDR path: times the capture window from the READ
// strobe and assembles 32-bit words from the rise/fall halves of the IDDR2 cells.
module hpdmc_ddr_rdcapture #(
  parameter int unsigned BURST_CYCLES = 4,
  parameter int unsigned MAX_DELAY    = 15
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst,
  input  logic                                 rd_issue,
  input  logic [$clog2(MAX_DELAY+1)-1:0]       rd_delay,
  input  logic                                 half_swap,
  input  logic [15:0]                          q_rise,
  input  logic [15:0]                          q_fall,
  output logic [31:0]                          dout,
  output logic                                 dout_valid,
  output logic                                 dout_last,
  output logic                                 overflow
);

  localparam int unsigned CW = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam int unsigned DW = $clog2(MAX_DELAY + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_CYCLES - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_CAPT = 1'b1;

  // dline_q[i] is rd_issue delayed by i+1 cycles
  logic [MAX_DELAY-1:0] dline_q;
  logic [DW-1:0]        delay_eff;
  logic                 start;

  logic                 state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        idx;
  logic                 win;
  logic [15:0]          q_fall_q;
  logic [31:0]          word;

  logic [31:0]          dout_d;
  logic                 dout_valid_d;
  logic                 dout_last_d;
  logic                 overflow_d;

  assign delay_eff = (rd_delay == '0) ? DW'(1) : rd_delay;
  assign start     = dline_q[delay_eff - DW'(1)];

  // The start cycle is itself the first window cycle (index 0)
  assign win  = start | (state_q == ST_CAPT);
  assign idx  = start ? '0 : cnt_q;
  assign word = half_swap ? {q_fall_q, q_rise} : {q_rise, q_fall};

  always_comb begin
    state_d      = ST_IDLE;
    cnt_d        = '0;
    dout_d       = dout;
    dout_valid_d = 1'b0;
    dout_last_d  = 1'b0;
    // A start while the previous burst still had words to deliver truncates it
    overflow_d   = overflow | (start & (state_q == ST_CAPT));
    if (win) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
      dout_last_d  = (idx == LAST_IDX);
      if (idx != LAST_IDX) begin
        state_d = ST_CAPT;
        cnt_d   = idx + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dline_q    <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      q_fall_q   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dline_q    <= {dline_q[MAX_DELAY-2:0], rd_issue};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_fall_q   <= q_fall;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      dout_last  <= dout_last_d;
      overflow   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_hpdmc_ddr_rdcapture.sv
// Bench for hpdmc_ddr_rdcapture: directed scenarios plus random traffic, all checked
// against a burst-start-time reference model.
module tb_hpdmc_ddr_rdcapture;

  localparam int BC = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rd_issue = 1'b0;
  logic [3:0]  rd_delay = 4'd0;
  logic        half_swap = 1'b0;
  logic [15:0] q_rise = 16'h0;
  logic [15:0] q_fall = 16'h0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  hpdmc_ddr_rdcapture #(
    .BURST_CYCLES(4),
    .MAX_DELAY   (15)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rd_issue  (rd_issue),
    .rd_delay  (rd_delay),
    .half_swap (half_swap),
    .q_rise    (q_rise),
    .q_fall    (q_fall),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .overflow  (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: bursts tracked by their start cycle
  int          cyc = 0;
  int          base = 0;
  int          issues[$];
  int          cur_start = -1000;
  logic        m_valid = 1'b0;
  logic        m_last = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_dout = 32'h0;
  logic [15:0] m_fall_d = 16'h0;

  // Per-scenario observation log, indexed by cycle relative to base
  int          vq[$];
  int          lq[$];
  int          ovf_first = -1;
  logic [31:0] dat [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    int   d;
    int   idx;
    int   rel;
    logic start;
    logic active;
    d = (rd_delay == 4'd0) ? 1 : int'(rd_delay);
    start = 1'b0;
    foreach (issues[i]) if (issues[i] + d == cyc) start = 1'b1;
    if (sys_rst) begin
      issues.delete();
      cur_start = -1000;
      m_valid = 1'b0;
      m_last = 1'b0;
      m_ovf = 1'b0;
      m_dout = 32'h0;
      m_fall_d = 16'h0;
    end else begin
      if (rd_issue) issues.push_back(cyc);
      if (start) begin
        if (cyc - cur_start < BC) m_ovf = 1'b1;
        cur_start = cyc;
      end
      idx = cyc - cur_start;
      active = (idx >= 0) && (idx < BC);
      m_valid = active;
      m_last = active && (idx == BC - 1);
      if (active) m_dout = half_swap ? {m_fall_d, q_rise} : {q_rise, q_fall};
      m_fall_d = q_fall;
    end
    @(posedge sys_clk);
    #1;
    check("dout_valid", {31'h0, dout_valid}, {31'h0, m_valid});
    check("dout_last", {31'h0, dout_last}, {31'h0, m_last});
    check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
    check("dout", dout, m_dout);
    rel = cyc - base + 1;
    if (dout_valid) vq.push_back(rel);
    if (dout_last) lq.push_back(rel);
    if (overflow && ovf_first < 0) ovf_first = rel;
    if (rel >= 0 && rel < 64) dat[rel] = dout;
    cyc++;
  endtask

  // Relative cycle numbering; reset at r=0 and optionally at rst_at
  task automatic run_scn(input int d, input bit hs, input int t1, input int t2, input int rst_at);
    base = cyc;
    vq.delete();
    lq.delete();
    ovf_first = -1;
    rd_delay = 4'(d);
    half_swap = hs;
    for (int r = 0; r < 40; r++) begin
      sys_rst = (r == 0) || (r == rst_at);
      rd_issue = (r == t1) || (r == t2);
      q_rise = 16'hA000 + 16'(r);
      q_fall = 16'hB000 + 16'(r);
      step();
    end
  endtask

  initial begin
    // 1: basic burst
    run_scn(3, 1'b0, 10, -1, -1);
    check("s1_nvalid", 32'(vq.size()), 32'd4);
    if (vq.size() == 4) begin
      check("s1_first", 32'(vq[0]), 32'd14);
      check("s1_lastv", 32'(vq[3]), 32'd17);
    end
    check("s1_nlast", 32'(lq.size()), 32'd1);
    if (lq.size() == 1) check("s1_lastpos", 32'(lq[0]), 32'd17);
    check("s1_d14", dat[14], 32'hA00D_B00D);
    check("s1_ovf", {31'h0, overflow}, 32'd0);

    // 2: half swap
    run_scn(3, 1'b1, 10, -1, -1);
    check("s2_d14", dat[14], 32'hB00C_A00D);
    check("s2_d15", dat[15], 32'hB00D_A00E);

    // 3: back-to-back bursts
    run_scn(2, 1'b0, 10, 14, -1);
    check("s3_nvalid", 32'(vq.size()), 32'd8);
    if (vq.size() == 8) begin
      check("s3_first", 32'(vq[0]), 32'd13);
      check("s3_lastv", 32'(vq[7]), 32'd20);
    end
    check("s3_nlast", 32'(lq.size()), 32'd2);
    if (lq.size() == 2) begin
      check("s3_last0", 32'(lq[0]), 32'd16);
      check("s3_last1", 32'(lq[1]), 32'd20);
    end
    check("s3_ovf", {31'h0, overflow}, 32'd0);

    // 4: truncated burst
    run_scn(2, 1'b0, 10, 12, -1);
    check("s4_ovf_first", 32'(ovf_first), 32'd15);
    check("s4_nvalid", 32'(vq.size()), 32'd6);
    if (vq.size() == 6) begin
      check("s4_first", 32'(vq[0]), 32'd13);
      check("s4_lastv", 32'(vq[5]), 32'd18);
    end
    check("s4_nlast", 32'(lq.size()), 32'd1);
    if (lq.size() == 1) check("s4_lastpos", 32'(lq[0]), 32'd18);
    check("s4_ovf", {31'h0, overflow}, 32'd1);

    // 5: delay extremes
    run_scn(0, 1'b0, 10, -1, -1);
    if (vq.size() > 0) check("s5_d0_first", 32'(vq[0]), 32'd12);
    else check("s5_d0_nvalid", 32'(vq.size()), 32'd4);
    run_scn(15, 1'b0, 10, -1, -1);
    if (vq.size() > 0) check("s5_d15_first", 32'(vq[0]), 32'd26);
    else check("s5_d15_nvalid", 32'(vq.size()), 32'd4);

    // 6: reset mid-burst, then a clean burst
    run_scn(3, 1'b0, 10, 20, 14);
    check("s6_nvalid", 32'(vq.size()), 32'd5);
    if (vq.size() == 5) begin
      check("s6_v0", 32'(vq[0]), 32'd14);
      check("s6_v1", 32'(vq[1]), 32'd24);
    end
    check("s6_nlast", 32'(lq.size()), 32'd1);
    check("s6_ovf", {31'h0, overflow}, 32'd0);

    // Random traffic, delay held per block
    for (int b = 0; b < 4; b++) begin
      base = cyc;
      sys_rst = 1'b1;
      rd_issue = 1'b0;
      rd_delay = 4'($urandom_range(0, 15));
      step();
      sys_rst = 1'b0;
      for (int r = 0; r < 300; r++) begin
        rd_issue = ($urandom_range(0, 5) == 0);
        half_swap = 1'($urandom_range(0, 1));
        q_rise = 16'($urandom);
        q_fall = 16'($urandom);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
